data_mem_ctrl: RTL

// - Responder side of the processor's data-memory interface: services dm_en writes and ar_out reads.
// - Adds a host-side stream loader that fills memory before a run, and a dumper that streams results out after end_process.
// - Sits between the processor top and the FPGA host link; the processor is held off until the load completes.

---
 rtl/data_mem_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-memory responder with host stream loader and result dumper.
// Optional macro DMC_FWD_EN selects write-first forwarding on the processor read port.
module data_mem_ctrl #(
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 12,
    parameter int                BUS_W     = 17,
    parameter logic [ADDR_W-1:0] LOAD_BASE = '0,
    parameter logic [ADDR_W-1:0] DUMP_BASE = '0,
    parameter int                N_WORDS   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              cpu_run,
    input  logic [ADDR_W-1:0] ar_in,
    input  logic              dm_en,
    input  logic [BUS_W-1:0]  bus_in,
    output logic [DATA_W-1:0] dm_out,
    input  logic              end_process,
    output logic              dp_valid,
    output logic [DATA_W-1:0] dp_data,
    input  logic              dp_ready,
    output logic              done
);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] NW = CW'(N_WORDS);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, DONE} state_t;

    state_t            state, nxt;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [CW-1:0]     cnt;
    logic              ld_hs, dp_hs, fetch, we;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [DATA_W-1:0] wdata;
    logic              unused_bus;

    assign unused_bus = ^bus_in[BUS_W-1:DATA_W];

    // Next state, status outputs, handshakes and memory port steering
    always_comb begin
        nxt      = state;
        ld_ready = state == LOAD;
        cpu_run  = state == RUN;
        done     = state == DONE;
        ld_hs    = ld_ready && ld_valid;
        dp_hs    = state == DUMP && dp_valid && dp_ready;
        fetch    = state == DUMP && (!dp_valid || dp_ready) && cnt != NW;
        we       = !rst && (ld_hs || (cpu_run && dm_en));
        waddr    = ld_ready ? LOAD_BASE + cnt[ADDR_W-1:0] : ar_in;
        wdata    = ld_ready ? ld_data : bus_in[DATA_W-1:0];
        raddr    = cpu_run ? ar_in : DUMP_BASE + cnt[ADDR_W-1:0];
        case (state)
            IDLE, DONE: if (start) nxt = LOAD;
            LOAD:       if (ld_hs && cnt == NW - 1'b1) nxt = RUN;
            RUN:        if (end_process) nxt = DUMP;
            DUMP:       if (dp_hs && cnt == NW) nxt = DONE;
            default:    nxt = IDLE;
        endcase
    end

    // State register; cnt counts load handshakes in LOAD and issued reads in DUMP
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state) ? '0 : cnt + CW'(ld_hs || fetch);
        end
    end

    // Single write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered reads: processor port in RUN, dump prefetch register in DUMP
    always_ff @(posedge clk) begin
        if (rst) begin
            dm_out   <= '0;
            dp_valid <= 1'b0;
            dp_data  <= '0;
        end else begin
`ifdef DMC_FWD_EN
            if (cpu_run) dm_out <= dm_en ? bus_in[DATA_W-1:0] : mem[raddr];
`else
            if (cpu_run) dm_out <= mem[raddr];
`endif
            if (fetch) dp_data <= mem[raddr];
            if (state == DUMP && (!dp_valid || dp_ready)) dp_valid <= fetch;
        end
    end
endmodule
